// File: rtl/zxuno_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zxuno_reg_arbiter_pkg
// Brief    : Shared constants and FSM state encoding for the ZXUNO register
//            access-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package zxuno_reg_arbiter_pkg;

  // CPU I/O ports of the register file
  localparam logic [15:0] IOADDR_DEFAULT = 16'hFC3B;
  localparam logic [15:0] IODATA_DEFAULT = 16'hFD3B;

  // Idle cycles needed before a master strobe, and master strobe length
  localparam int GUARD_DEFAULT = 2;
  localparam int HOLD_DEFAULT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/zxuno_cpu_iodecode.sv
`default_nettype none
// ============================================================================
// Module   : zxuno_cpu_iodecode
// Brief    : Z80 I/O cycle decode for the register file ports and the
//            CPU-selected register address register.
// Revision : 1.0 - initial release
// ============================================================================
module zxuno_cpu_iodecode
  import zxuno_reg_arbiter_pkg::*;
#(
  parameter logic [15:0] IOADDR = IOADDR_DEFAULT,
  parameter logic [15:0] IODATA = IODATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  cpu_addr,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        cpu_rd,
  output logic        cpu_wr,
  output logic        regaddr_changed
);

  logic       w_addr_wr;
  logic [7:0] r_cpu_addr;
  logic       r_changed;

  assign w_addr_wr = !iorq_n && !wr_n && (a == IOADDR);
  assign oe        = !iorq_n && !rd_n && (a == IOADDR);
  assign dout      = oe ? r_cpu_addr : 8'h00;
  assign cpu_rd    = !iorq_n && !rd_n && (a == IODATA);
  assign cpu_wr    = !iorq_n && !wr_n && (a == IODATA);

  // Register address select; changed flag is set by reset so peripherals resync
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_addr <= 8'h00;
      r_changed  <= 1'b1;
    end else begin
      r_changed <= w_addr_wr;
      if (w_addr_wr) begin
        r_cpu_addr <= din;
      end
    end
  end

  assign cpu_addr        = r_cpu_addr;
  assign regaddr_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/zxuno_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zxuno_reg_arbiter
// Brief    : Shares the ZXUNO register access port between the Z80 I/O path
//            and one secondary master. The CPU always has priority; a master
//            access only strobes after the bus has been idle for GUARD cycles
//            and is restarted if the CPU starts an I/O cycle mid-strobe.
// Revision : 1.0 - initial release
// ============================================================================
module zxuno_reg_arbiter
  import zxuno_reg_arbiter_pkg::*;
#(
  parameter logic [15:0] IOADDR = IOADDR_DEFAULT,
  parameter logic [15:0] IODATA = IODATA_DEFAULT,
  parameter int          GUARD  = GUARD_DEFAULT,
  parameter int          HOLD   = HOLD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [7:0]  m_addr,
  input  logic [7:0]  m_wdata,
  output logic        m_ack,
  output logic [7:0]  m_rdata,
  input  logic [7:0]  reg_rdata,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic        regaddr_changed
);

  localparam int            GW          = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [GW-1:0] C_GUARD_MAX = GW'(GUARD);
  localparam logic [2:0]    C_HOLD_LAST = 3'(HOLD - 1);

  logic [7:0]    w_cpu_addr;
  logic          w_cpu_rd;
  logic          w_cpu_wr;
  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [GW-1:0] r_guard;
  logic [2:0]    r_hold;
  logic [2:0]    w_hold_nxt;
  logic          r_m_we;
  logic [7:0]    r_m_addr;
  logic [7:0]    r_m_wdata;
  logic [7:0]    r_m_rdata;
  logic [7:0]    w_m_rdata_nxt;
  logic          w_master_owns;
  logic          w_m_ack;

  zxuno_cpu_iodecode #(
    .IOADDR (IOADDR),
    .IODATA (IODATA)
  ) u_iodecode (
    .clk             (clk),
    .rst             (rst),
    .a               (a),
    .iorq_n          (iorq_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .din             (din),
    .cpu_addr        (w_cpu_addr),
    .dout            (dout),
    .oe              (oe),
    .cpu_rd          (w_cpu_rd),
    .cpu_wr          (w_cpu_wr),
    .regaddr_changed (regaddr_changed)
  );

  // Count consecutive idle bus cycles, saturating at GUARD
  always_ff @(posedge clk) begin
    if (rst || !iorq_n) begin
      r_guard <= '0;
    end else if (r_guard != C_GUARD_MAX) begin
      r_guard <= r_guard + 1'b1;
    end
  end

  // Capture the master command at acceptance so a dropped m_req cannot corrupt it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_we    <= 1'b0;
      r_m_addr  <= 8'h00;
      r_m_wdata <= 8'h00;
    end else if ((r_state == ST_IDLE) && m_req) begin
      r_m_we    <= m_we;
      r_m_addr  <= m_addr;
      r_m_wdata <= m_wdata;
    end
  end

  // FSM state, hold counter and master read data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= 3'd0;
      r_m_rdata <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_m_rdata <= w_m_rdata_nxt;
    end
  end

  // Next-state logic; any CPU I/O cycle during STROBE aborts back to WAIT
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_m_rdata_nxt = r_m_rdata;
    w_master_owns = 1'b0;
    w_m_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hold_nxt = 3'd0;
        if (m_req) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_hold_nxt = 3'd0;
        if ((r_guard == C_GUARD_MAX) && iorq_n) begin
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!iorq_n) begin
          w_state_nxt = ST_WAIT;
          w_hold_nxt  = 3'd0;
        end else begin
          w_master_owns = 1'b1;
          if (r_hold == C_HOLD_LAST) begin
            w_hold_nxt  = 3'd0;
            w_state_nxt = ST_DONE;
            if (!r_m_we) begin
              w_m_rdata_nxt = reg_rdata;
            end
          end else begin
            w_hold_nxt = r_hold + 3'd1;
          end
        end
      end
      ST_DONE: begin
        // Ack is held off while the CPU is strobing the port
        if (!(w_cpu_rd || w_cpu_wr)) begin
          w_m_ack     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register port mux: master drives only while it owns an uncontested strobe
  always_comb begin
    reg_addr  = w_cpu_addr;
    reg_wdata = din;
    reg_rd    = w_cpu_rd;
    reg_wr    = w_cpu_wr;
    if (w_master_owns) begin
      reg_addr  = r_m_addr;
      reg_wdata = r_m_wdata;
      reg_rd    = !r_m_we;
      reg_wr    = r_m_we;
    end
  end

  assign m_ack   = w_m_ack;
  assign m_rdata = r_m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_zxuno_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zxuno_reg_arbiter
// Brief    : Self-checking bench for zxuno_reg_arbiter: table of CPU-path
//            vectors followed by hand-written master access sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zxuno_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        m_req;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack;
  logic [7:0]  m_rdata;
  logic [7:0]  reg_rdata;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_rd;
  logic        reg_wr;
  logic        regaddr_changed;

  int n_vec;
  int n_err;
  int acks;
  int wrs;

  typedef struct {
    logic        rst;
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic        e_oe;
    logic [7:0]  e_dout;
    logic [7:0]  e_raddr;
    logic [7:0]  e_wdata;
    logic        e_rd;
    logic        e_wr;
    logic        e_chg;
  } vec_t;

  vec_t tv [0:20];

  zxuno_reg_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .a               (a),
    .iorq_n          (iorq_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .din             (din),
    .dout            (dout),
    .oe              (oe),
    .m_req           (m_req),
    .m_we            (m_we),
    .m_addr          (m_addr),
    .m_wdata         (m_wdata),
    .m_ack           (m_ack),
    .m_rdata         (m_rdata),
    .reg_rdata       (reg_rdata),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rd          (reg_rd),
    .reg_wr          (reg_wr),
    .regaddr_changed (regaddr_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic r, input logic [15:0] aa, input logic io,
                               input logic rr, input logic ww, input logic [7:0] d,
                               input logic eoe, input logic [7:0] edo, input logic [7:0] era,
                               input logic [7:0] ewd, input logic erd, input logic ewr,
                               input logic ech);
    vec_t v;
    v.rst = r; v.a = aa; v.iorq_n = io; v.rd_n = rr; v.wr_n = ww; v.din = d;
    v.e_oe = eoe; v.e_dout = edo; v.e_raddr = era; v.e_wdata = ewd;
    v.e_rd = erd; v.e_wr = ewr; v.e_chg = ech;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; din = 8'h00;
  endtask

  initial begin
    n_vec = 0; n_err = 0; acks = 0; wrs = 0;
    rst = 1'b1;
    cpu_idle();
    m_req = 1'b0; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00; reg_rdata = 8'h00;

    //            rst a        io rd wr din  | oe dout raddr wdata rd wr chg
    tv[0]  = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[1]  = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[2]  = mkv(0, 16'hFC3B, 0, 1, 0, 8'h0B, 0, 8'h00, 8'h00, 8'h0B, 0, 0, 0);
    tv[3]  = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 1);
    tv[4]  = mkv(0, 16'hFC3B, 0, 0, 1, 8'h00, 1, 8'h0B, 8'h0B, 8'h00, 0, 0, 0);
    tv[5]  = mkv(0, 16'hFD3B, 0, 1, 0, 8'h55, 0, 8'h00, 8'h0B, 8'h55, 0, 1, 0);
    tv[6]  = mkv(0, 16'hFD3B, 0, 0, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 1, 0, 0);
    tv[7]  = mkv(0, 16'h00FE, 0, 0, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0);
    tv[8]  = mkv(0, 16'hFC3A, 0, 1, 0, 8'h99, 0, 8'h00, 8'h0B, 8'h99, 0, 0, 0);
    tv[9]  = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0);
    tv[10] = mkv(0, 16'hFC3B, 1, 0, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0);
    tv[11] = mkv(0, 16'hFC3B, 0, 1, 0, 8'h22, 0, 8'h00, 8'h0B, 8'h22, 0, 0, 0);
    tv[12] = mkv(0, 16'hFC3B, 0, 1, 0, 8'h22, 0, 8'h00, 8'h22, 8'h22, 0, 0, 1);
    tv[13] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h22, 8'h00, 0, 0, 1);
    tv[14] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h22, 8'h00, 0, 0, 0);
    tv[15] = mkv(1, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h22, 8'h00, 0, 0, 0);
    tv[16] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[17] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[18] = mkv(0, 16'hFC3B, 0, 1, 0, 8'h0B, 0, 8'h00, 8'h00, 8'h0B, 0, 0, 0);
    tv[19] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 1);
    tv[20] = mkv(0, 16'h0000, 1, 1, 1, 8'h00, 0, 8'h00, 8'h0B, 8'h00, 0, 0, 0);

    tick();
    rst = 1'b0;

    // CPU path vectors, one clock each
    for (int i = 0; i <= 20; i++) begin
      rst = tv[i].rst; a = tv[i].a; iorq_n = tv[i].iorq_n;
      rd_n = tv[i].rd_n; wr_n = tv[i].wr_n; din = tv[i].din;
      #2;
      chk($sformatf("v%0d.oe", i),    {7'b0, oe},              {7'b0, tv[i].e_oe});
      chk($sformatf("v%0d.dout", i),  dout,                    tv[i].e_dout);
      chk($sformatf("v%0d.raddr", i), reg_addr,                tv[i].e_raddr);
      chk($sformatf("v%0d.wdata", i), reg_wdata,               tv[i].e_wdata);
      chk($sformatf("v%0d.rd", i),    {7'b0, reg_rd},          {7'b0, tv[i].e_rd});
      chk($sformatf("v%0d.wr", i),    {7'b0, reg_wr},          {7'b0, tv[i].e_wr});
      chk($sformatf("v%0d.chg", i),   {7'b0, regaddr_changed}, {7'b0, tv[i].e_chg});
      chk($sformatf("v%0d.ack", i),   {7'b0, m_ack},           8'h00);
      tick();
    end
    rst = 1'b0;
    cpu_idle();

    // Master write 2A -> 0E on an idle bus
    m_req = 1'b1; m_we = 1'b1; m_addr = 8'h0E; m_wdata = 8'h2A;
    #2; chk("A0.wr", {7'b0, reg_wr}, 8'h00); chk("A0.ack", {7'b0, m_ack}, 8'h00);
    tick();
    #2; chk("A1.wr", {7'b0, reg_wr}, 8'h00); chk("A1.raddr", reg_addr, 8'h0B);
    tick();
    #2; chk("A2.wr", {7'b0, reg_wr}, 8'h01); chk("A2.rd", {7'b0, reg_rd}, 8'h00);
    chk("A2.raddr", reg_addr, 8'h0E); chk("A2.wdata", reg_wdata, 8'h2A);
    chk("A2.ack", {7'b0, m_ack}, 8'h00); chk("A2.chg", {7'b0, regaddr_changed}, 8'h00);
    tick();
    #2; chk("A3.ack", {7'b0, m_ack}, 8'h01); chk("A3.wr", {7'b0, reg_wr}, 8'h00);
    chk("A3.raddr", reg_addr, 8'h0B); chk("A3.rdata", m_rdata, 8'h00);
    chk("A3.chg", {7'b0, regaddr_changed}, 8'h00);
    m_req = 1'b0;
    tick();
    #2; chk("A4.ack", {7'b0, m_ack}, 8'h00); chk("A4.raddr", reg_addr, 8'h0B);
    chk("A4.chg", {7'b0, regaddr_changed}, 8'h00);
    tick();

    // Master read of register 07
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h07; reg_rdata = 8'hA5;
    #2; chk("B0.rd", {7'b0, reg_rd}, 8'h00);
    tick();
    #2; chk("B1.rd", {7'b0, reg_rd}, 8'h00);
    tick();
    #2; chk("B2.rd", {7'b0, reg_rd}, 8'h01); chk("B2.wr", {7'b0, reg_wr}, 8'h00);
    chk("B2.raddr", reg_addr, 8'h07); chk("B2.ack", {7'b0, m_ack}, 8'h00);
    tick();
    #2; chk("B3.ack", {7'b0, m_ack}, 8'h01); chk("B3.rdata", m_rdata, 8'hA5);
    m_req = 1'b0;
    tick();
    #2; chk("B4.ack", {7'b0, m_ack}, 8'h00); chk("B4.rdata", m_rdata, 8'hA5);
    tick();

    // CPU I/O cycle lands in the master STROBE cycle
    m_req = 1'b1; m_we = 1'b0; m_addr = 8'h09; reg_rdata = 8'h3C; acks = 0;
    #2; acks += int'(m_ack);
    tick();
    #2; acks += int'(m_ack);
    tick();
    a = 16'hFD3B; iorq_n = 1'b0; wr_n = 1'b0; din = 8'h77;
    #2; acks += int'(m_ack);
    chk("C2.wr", {7'b0, reg_wr}, 8'h01); chk("C2.rd", {7'b0, reg_rd}, 8'h00);
    chk("C2.raddr", reg_addr, 8'h0B); chk("C2.wdata", reg_wdata, 8'h77);
    chk("C2.ack", {7'b0, m_ack}, 8'h00);
    tick();
    cpu_idle();
    reg_rdata = 8'hC3;
    for (int k = 3; k <= 5; k++) begin
      #2; acks += int'(m_ack);
      chk($sformatf("C%0d.rd", k), {7'b0, reg_rd}, 8'h00);
      tick();
    end
    #2; acks += int'(m_ack);
    chk("C6.rd", {7'b0, reg_rd}, 8'h01); chk("C6.raddr", reg_addr, 8'h09);
    tick();
    #2; acks += int'(m_ack);
    chk("C7.ack", {7'b0, m_ack}, 8'h01); chk("C7.rdata", m_rdata, 8'hC3);
    m_req = 1'b0;
    tick();
    for (int k = 8; k <= 10; k++) begin
      #2; acks += int'(m_ack);
      tick();
    end
    chk("C.ack_count", 8'(acks), 8'h01);

    // Reset during STROBE: strobe drops at next edge, no ack follows
    m_req = 1'b1; m_we = 1'b1; m_addr = 8'h44; m_wdata = 8'h66;
    tick();
    tick();
    rst = 1'b1;
    #2; chk("D2.wr", {7'b0, reg_wr}, 8'h01); chk("D2.raddr", reg_addr, 8'h44);
    tick();
    rst = 1'b0; m_req = 1'b0; acks = 0; wrs = 0;
    #2; chk("D3.wr", {7'b0, reg_wr}, 8'h00); chk("D3.chg", {7'b0, regaddr_changed}, 8'h01);
    chk("D3.raddr", reg_addr, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #2; acks += int'(m_ack);
      tick();
    end
    chk("D.no_ack", 8'(acks), 8'h00);

    // Request withdrawn while waiting: access still completes with one ack
    m_req = 1'b1; m_we = 1'b1; m_addr = 8'h11; m_wdata = 8'h12; acks = 0; wrs = 0;
    #2; acks += int'(m_ack); wrs += int'(reg_wr);
    tick();
    m_req = 1'b0; m_addr = 8'hFF; m_wdata = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      #2; acks += int'(m_ack); wrs += int'(reg_wr);
      if (reg_wr) chk("E.waddr", reg_addr, 8'h11);
      tick();
    end
    chk("E.ack_count", 8'(acks), 8'h01);
    chk("E.wr_count", 8'(wrs), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
